// File: rtl/demux_1_to_4_buf_pkg.sv
// Shared settings for the word mux/demux family: default word width and lane encodings.
// Imported by the 1:4 buffered demux and its per-lane FIFO.
package demux_1_to_4_buf_pkg;

   localparam int WORD_WIDTH_DEFAULT = 32;
   localparam int NUM_LANES          = 4;

   localparam logic [1:0] LANE1 = 2'b00;
   localparam logic [1:0] LANE2 = 2'b01;
   localparam logic [1:0] LANE3 = 2'b10;
   localparam logic [1:0] LANE4 = 2'b11;

   function automatic logic [NUM_LANES-1:0] lane_decode(input logic [1:0] sel);
      logic [NUM_LANES-1:0] onehot;
      onehot = '0;
      onehot[sel] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry FIFO for one demux lane: register pair with 1-bit wrapping pointers and a 2-bit count.
// The head word is read combinationally from the entry at the read pointer.
module demux_lane_fifo
   import demux_1_to_4_buf_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [WORD_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [WORD_WIDTH-1:0] head_data,
   output logic [1:0]            count
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [WORD_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         // On a full lane a simultaneous push overwrites the slot being popped this edge.
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (count <= FULL)
            else $error("lane fifo count above depth");
         assert (!(pop && count == 2'd0))
            else $error("lane fifo popped while empty");
         assert (!(push && !pop && count == FULL))
            else $error("lane fifo pushed while full");
      end
   end

endmodule

// File: rtl/demux_1_to_4_buf.sv
// Buffered 1:4 word demux: routes one valid/ready stream to four lanes, each with its own 2-entry FIFO.
// A stalled consumer blocks only its own lane; in_ready looks at the selected lane only.
module demux_1_to_4_buf
   import demux_1_to_4_buf_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [1:0]            in_sel,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [3:0]            out_valid,
   output logic [4*WORD_WIDTH-1:0] out_data,
   input  logic [3:0]            out_ready,
   output logic [7:0]            out_count
);

   localparam logic [1:0] LANE_FULL = 2'(DEPTH);

   logic [1:0]           lane_count [NUM_LANES];
   logic [NUM_LANES-1:0] sel_onehot;
   logic [NUM_LANES-1:0] lane_push;
   logic [NUM_LANES-1:0] lane_pop;
   logic                 accept;

   // A full lane still accepts when its head leaves on the same edge.
   assign in_ready   = rst_n && ((lane_count[in_sel] < LANE_FULL) || out_ready[in_sel]);
   assign accept     = in_valid && in_ready;
   assign sel_onehot = lane_decode(in_sel);
   assign lane_push  = accept ? sel_onehot : '0;
   assign lane_pop   = out_valid & out_ready;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      demux_lane_fifo #(
         .WORD_WIDTH (WORD_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (lane_push[i]),
         .push_data (in_data),
         .pop       (lane_pop[i]),
         .head_data (out_data[i*WORD_WIDTH +: WORD_WIDTH]),
         .count     (lane_count[i])
      );

      assign out_valid[i]        = (lane_count[i] != 2'd0);
      assign out_count[2*i +: 2] = lane_count[i];
   end

endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Self-checking bench for the buffered 1:4 demux: directed scenarios plus a randomized run
// against per-lane queue models.
module tb_demux_1_to_4_buf;
   import demux_1_to_4_buf_pkg::*;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic [1:0]     in_sel;
   logic [W-1:0]   in_data;
   logic           in_ready;
   logic [3:0]     out_valid;
   logic [4*W-1:0] out_data;
   logic [3:0]     out_ready;
   logic [7:0]     out_count;

   int n_cmp = 0;
   int n_err = 0;

   demux_1_to_4_buf #(.WORD_WIDTH(W), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [3:0] ordy);
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      drive(1'b0, LANE1, '0, 4'hF);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, LANE1, 32'hDEAD_BEEF, 4'h0);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      tick(); tick();
      n_cmp++;
      if (out_valid !== 4'b0 || out_count !== 8'h0 || out_data !== '0) begin
         n_err++;
         $display("FAIL reset_state got valid=%b count=%h data=%h want 0", out_valid, out_count, out_data);
      end
      rst_n = 1'b1;
      drive(1'b0, LANE1, '0, 4'h0);
      tick();
   endtask

   task automatic test_single();
      drive(1'b1, LANE3, 32'hA5A5_A5A5, 4'hF);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL single_in_ready got %b want 1", in_ready);
      end
      tick();
      drive(1'b0, LANE1, '0, 4'hF);
      n_cmp++;
      if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 32'hA5A5_A5A5 || out_count[5:4] !== 2'd1) begin
         n_err++;
         $display("FAIL single_out got valid=%b data=%h cnt=%0d want 0100 a5a5a5a5 1",
                  out_valid, out_data[2*W +: W], out_count[5:4]);
      end
      tick();
      n_cmp++;
      if (out_valid !== 4'b0 || out_count !== 8'h0) begin
         n_err++; $display("FAIL single_drain got valid=%b count=%h want 0", out_valid, out_count);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, LANE1, 32'h1, 4'h0); tick();
      drive(1'b1, LANE1, 32'h2, 4'h0); tick();
      drive(1'b1, LANE1, 32'h9, 4'h0);
      n_cmp++;
      if (in_ready !== 1'b0 || out_count[1:0] !== 2'd2) begin
         n_err++; $display("FAIL bp_full got ready=%b cnt=%0d want 0 2", in_ready, out_count[1:0]);
      end
      drive(1'b1, LANE2, 32'h3, 4'h0);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_other_lane got ready=%b want 1", in_ready);
      end
      tick();
      drive(1'b0, LANE1, '0, 4'b0001);
      n_cmp++;
      if (out_count !== 8'h06 || out_data[W-1:0] !== 32'h1) begin
         n_err++; $display("FAIL bp_head1 got count=%h data=%h want 06 1", out_count, out_data[W-1:0]);
      end
      tick();
      n_cmp++;
      if (out_data[W-1:0] !== 32'h2 || out_count[1:0] !== 2'd1 || out_data[W +: W] !== 32'h3) begin
         n_err++;
         $display("FAIL bp_head2 got data=%h cnt=%0d lane1=%h want 2 1 3",
                  out_data[W-1:0], out_count[1:0], out_data[W +: W]);
      end
      tick();
      n_cmp++;
      if (out_valid !== 4'b0010) begin
         n_err++; $display("FAIL bp_drained got valid=%b want 0010", out_valid);
      end
      flush();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, LANE4, 32'h10, 4'h0); tick();
      drive(1'b1, LANE4, 32'h11, 4'h0); tick();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, LANE4, 32'h12 + 32'(k), 4'b1000);
         n_cmp++;
         if (in_ready !== 1'b1 || out_count[7:6] !== 2'd2 || out_data[3*W +: W] !== 32'h10 + 32'(k)) begin
            n_err++;
            $display("FAIL b2b_%0d got ready=%b cnt=%0d data=%h want 1 2 %h",
                     k, in_ready, out_count[7:6], out_data[3*W +: W], 32'h10 + 32'(k));
         end
         tick();
      end
      drive(1'b0, LANE1, '0, 4'b1000);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (out_valid[3] !== 1'b1 || out_data[3*W +: W] !== 32'h18 + 32'(k)) begin
            n_err++;
            $display("FAIL b2b_tail_%0d got v=%b data=%h want 1 %h",
                     k, out_valid[3], out_data[3*W +: W], 32'h18 + 32'(k));
         end
         tick();
      end
      n_cmp++;
      if (out_count !== 8'h0) begin
         n_err++; $display("FAIL b2b_empty got count=%h want 0", out_count);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, LANE1, 32'hB0, 4'h0); tick();
      drive(1'b1, LANE1, 32'hB1, 4'h0); tick();
      drive(1'b1, LANE3, 32'hC0, 4'h0); tick();
      drive(1'b1, LANE3, 32'hC1, 4'h0); tick();
      drive(1'b1, LANE2, 32'hD0, 4'h0); tick();
      n_cmp++;
      if (out_count !== 8'h26) begin
         n_err++; $display("FAIL rmid_fill got count=%h want 26", out_count);
      end
      rst_n = 1'b0;
      drive(1'b1, LANE2, 32'hEE, 4'hF);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL rmid_ready_low got %b want 0", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 4'b0 || out_count !== 8'h0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_cleared got valid=%b count=%h ready=%b want 0 0 0", out_valid, out_count, in_ready);
      end
      rst_n = 1'b1;
      drive(1'b0, LANE1, '0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (out_valid !== 4'b0) begin
            n_err++; $display("FAIL rmid_no_emit_%0d got valid=%b want 0000", k, out_valid);
         end
         tick();
      end
   endtask

   task automatic test_push_pop_one();
      drive(1'b1, LANE2, 32'h7, 4'h0); tick();
      drive(1'b1, LANE2, 32'h8, 4'b0010);
      n_cmp++;
      if (in_ready !== 1'b1 || out_data[W +: W] !== 32'h7) begin
         n_err++; $display("FAIL pp1_pre got ready=%b head=%h want 1 7", in_ready, out_data[W +: W]);
      end
      tick();
      drive(1'b0, LANE1, '0, 4'h0);
      n_cmp++;
      if (out_data[W +: W] !== 32'h8 || out_count[3:2] !== 2'd1) begin
         n_err++;
         $display("FAIL pp1_post got head=%h cnt=%0d want 8 1", out_data[W +: W], out_count[3:2]);
      end
      flush();
   endtask

   task automatic test_random();
      logic [W-1:0] mq [4][$];
      logic         exp_ready;
      logic [3:0]   ordy;
      int           bias;
      for (int i = 0; i < 4; i++) mq[i].delete();
      for (int c = 0; c < 10000; c++) begin
         bias = (c / 1000) % 4;
         for (int i = 0; i < 4; i++) ordy[i] = ($urandom_range(0, 3) < bias);
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, ordy);
         exp_ready = (mq[in_sel].size() < 2) || out_ready[in_sel];
         n_cmp++;
         if (in_ready !== exp_ready) begin
            n_err++; $display("FAIL rnd_ready cyc=%0d got %b want %b", c, in_ready, exp_ready);
         end
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_count[2*i +: 2] !== 2'(mq[i].size()) || out_valid[i] !== (mq[i].size() != 0)) begin
               n_err++;
               $display("FAIL rnd_count cyc=%0d lane=%0d got cnt=%0d v=%b want %0d",
                        c, i, out_count[2*i +: 2], out_valid[i], mq[i].size());
            end
            if (mq[i].size() != 0) begin
               n_cmp++;
               if (out_data[i*W +: W] !== mq[i][0]) begin
                  n_err++;
                  $display("FAIL rnd_data cyc=%0d lane=%0d got %h want %h", c, i, out_data[i*W +: W], mq[i][0]);
               end
               if (out_ready[i]) void'(mq[i].pop_front());
            end
         end
         if (in_valid && exp_ready) mq[in_sel].push_back(in_data);
         tick();
      end
      flush();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'b00;
      in_data   = '0;
      out_ready = 4'h0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_push_pop_one();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/demux_1_to_4_buf.md
Name: demux_1_to_4_buf

Overview:
- Inverse of the 4:1 word multiplexer: steers one incoming word stream to one of four destination streams, selected by a 2-bit `in_sel`.
- Each destination has a 2-entry FIFO, so a stalled consumer blocks only its own lane.
- Sits between a single producer (e.g. writeback/result bus) and four consumers (register banks, store path, I/O) that accept at independent rates.
- All handshakes are valid/ready.

Parameters:
- WORD_WIDTH, default `WORD_WIDTH (shared settings header, 32), data word width.
- DEPTH, default 2, entries per output FIFO; fixed at 2 in this revision, other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  producer has a word
- in_sel  input  2  destination lane: 00→out1, 01→out2, 10→out3, 11→out4
- in_data  input  WORD_WIDTH  word to route
- in_ready  output  1  word accepted this cycle when in_valid && in_ready
- out_valid  output  4  bit i: lane i holds a word
- out_data  output  4*WORD_WIDTH  lane i data at [i*WORD_WIDTH +: WORD_WIDTH]
- out_ready  input  4  bit i: consumer i takes head word
- out_count  output  8  lane i occupancy (0..2) at [2i+1:2i]

Behaviour:
- Reset (rst_n low at clock edge): all FIFOs empty; out_valid=0, out_count=0, out_data=0.
- While rst_n is low, in_ready=0 combinationally.
- Reset mid-transfer discards all buffered words; nothing is emitted for them.
- Accept rule: in_ready = rst_n && (count[in_sel] < 2 || out_ready[in_sel]).
  - A full lane popped in the same cycle accepts.
  - in_ready depends combinationally on in_sel and out_ready only, never on in_valid.
- Push: on an accepted transfer, in_data is written to the tail of lane in_sel at the clock edge.
- Latency: a word pushed into an empty lane appears on out_valid/out_data the next cycle. There is no same-cycle bypass.
- Pop: when out_valid[i] && out_ready[i], the head advances at the edge. out_ready while out_valid=0 is ignored.
- Per-lane count update:
  - push only → +1
  - pop only → −1
  - push and pop on a non-empty lane → unchanged, with the new word queued behind the remaining one
  - push and pop on a 1-entry lane → count stays 1, and the new word becomes head next cycle
- Ordering: strict FIFO order per lane. There is no ordering guarantee between lanes.
- Lanes are fully independent:
  - a full lane stalls the input only while in_sel targets it
  - pops on other lanes proceed every cycle
- out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.
- out_data[i] is don't-care (implementation holds its last value) when out_valid[i]=0.
- Overflow and underflow are impossible by construction. Assertions check count ≤ 2 and no pop when empty.
- Storage per lane: 2-entry register array with 1-bit read and write pointers that wrap modulo 2, plus a 2-bit count. out_valid[i] = (count≠0).

Decomposition:
- WORD_WIDTH comes from the shared settings header; no new package constants.
- Lane encoding constants (LANE1..LANE4 = 2'b00..2'b11) are added to the settings header, shared with the 4:1 mux users.
- One sub-module, demux_lane_fifo: clk, rst_n, push, push_data, pop, head_data, count.
  - Top instantiates four copies plus the decode and in_ready logic.

Test Plan:
1. Reset, then single word 0xA5A5A5A5 with in_sel=10 and all out_ready=1 → out_valid=0100 and out_data lane 2 = 0xA5A5A5A5 exactly one cycle after acceptance; out_count lane 2 returns to 0 the cycle after.
2. Lane 0 with out_ready[0]=0: push 0x1, 0x2 → in_ready=0 for in_sel=00, out_count[1:0]=2; a third push to in_sel=01 is accepted. Then raise out_ready[0] → 0x1 then 0x2 emerge in order.
3. Lane 3 full with out_ready[3]=1 and in_valid on in_sel=11 every cycle → in_ready stays 1, count stays 2, and 0x10,0x11,0x12… emerge in order with no gaps.
4. Random in_sel and random out_ready over 10k cycles against a per-lane scoreboard queue → no loss, duplication or reordering; count matches the model every cycle.
5. Fill lanes 0 and 2 to count 2 and lane 1 to count 1, then drive rst_n low for one edge → next cycle out_valid=0000, out_count=0, in_ready=0 while low; buffered words are never emitted.
6. Push and pop in the same cycle on a 1-entry lane (head 0x7, push 0x8) → next cycle head=0x8, count=1.
